// File: rtl/window_shift_controller.sv
// rtl/window_shift_controller.sv - KxK window sequencer: raster position tracking, shift enable, window-valid flagging
module window_shift_controller #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int KERNEL     = 3,
    parameter int CW         = 10,
    parameter int RW         = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          shift_en,
    output logic          win_valid,
    output logic [CW-1:0] win_col,
    output logic [RW-1:0] win_row,
    output logic          frame_done,
    output logic          sof_error,
    output logic          busy
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);
    localparam logic [CW-1:0] COL_OFS  = CW'((KERNEL - 1) / 2);
    localparam logic [RW-1:0] ROW_OFS  = RW'((KERNEL - 1) / 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          win_hit;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            RUN:     in_ready = out_ready | ~win_valid;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept   = in_valid & in_ready;
    // IDLE accepts without in_sof are discarded and must not disturb the window chain
    assign shift_en = accept & ((state != IDLE) | in_sof);
    assign busy     = (state == RUN);
    assign win_hit  = (col >= COL_MIN) & (row >= ROW_MIN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
            sof_error  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sof_error  <= 1'b0;

            case (state)
                IDLE: begin
                    if (shift_en) begin
                        state <= RUN;
                        col   <= CW'(1);
                        row   <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (in_sof) begin
                            col       <= CW'(1);
                            row       <= '0;
                            sof_error <= 1'b1;
                        end else if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row        <= '0;
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // A frame-start pixel is (0,0) and never completes a window, so any pending one is dropped
            if (shift_en) begin
                if ((state == RUN) && !in_sof && win_hit) begin
                    win_valid <= 1'b1;
                    win_col   <= col - COL_OFS;
                    win_row   <= row - ROW_OFS;
                end else begin
                    win_valid <= 1'b0;
                end
            end else if (out_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule
